// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: default sizes, the address-width
// helper and the per-port read record.
package regfile_pkg;

  localparam int REGFILE_DATA_W     = 8;
  localparam int REGFILE_NUM_REGS   = 8;
  // The read record carries up to this many data bits; narrower words use the
  // low bits and leave the rest at zero.
  localparam int REGFILE_MAX_DATA_W = 64;

  // One read port's registered result.
  typedef struct packed {
    logic [REGFILE_MAX_DATA_W-1:0] data;
    logic                          busy;
  } regfile_rd_t;

  // ceil(log2(n)), never less than 1 so a 2-entry file still has an address bit.
  function automatic int addr_width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file. One busy bit per register: set by an
// accepted reservation, cleared by a write-back, all cleared by flush.
//
// Reservation handshake: rsv is a one-cycle request with rsv_addr; rsv_ok is a
// same-cycle, purely combinational accept. A request that is not accepted has
// no effect and is not held; the requester simply retries. There is no stall.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = REGFILE_NUM_REGS,
  localparam int ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                rsv,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                flush,
  output logic                rsv_ok,
  output logic [NUM_REGS-1:0] busy_next
);

  logic [NUM_REGS-1:0] busy_q;
  logic                rsv_in_range;

  // Address range check; trivially true when NUM_REGS fills the address space.
  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : g_full
      assign rsv_in_range = 1'b1;
    end else begin : g_partial
      localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);
      assign rsv_in_range = ({1'b0, rsv_addr} < LIMIT);
    end
  endgenerate

  // Accept decision and next-state busy vector; flush overrides everything,
  // a same-cycle reserve beats the write-back clear on the same register.
  always_comb begin
    rsv_ok    = rsv && rsv_in_range &&
                (!busy_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
    busy_next = busy_q;
    if (wr_en)  busy_next[wr_addr]  = 1'b0;
    if (rsv_ok) busy_next[rsv_addr] = 1'b1;
    if (flush)  busy_next           = '0;
  end

  // Busy state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

endmodule

// File: rtl/register_file.sv
// NUM_REGS x DATA_W register file: one write-back port, two registered read
// ports with per-operand busy flags, and a reservation scoreboard.
// Optional build macro REGFILE_BYPASS_EN: a read of the register being written
// on the same edge returns the new value; without it the old value is returned.
// busy_a/busy_b always reflect the busy state after the current edge.
module register_file
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = REGFILE_DATA_W,
  parameter  int NUM_REGS = REGFILE_NUM_REGS,
  localparam int ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  input  logic              flush
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_next;
  logic                wr_en;
  logic                rd_ok_a;
  logic                rd_ok_b;
  regfile_rd_t         rd_a_d, rd_b_d;
  regfile_rd_t         rd_a_q, rd_b_q;

  // Range checks for write and read addresses (only matter when NUM_REGS is
  // not a power of two).
  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : g_full
      assign wr_en   = save;
      assign rd_ok_a = 1'b1;
      assign rd_ok_b = 1'b1;
    end else begin : g_partial
      localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);
      assign wr_en   = save && ({1'b0, wr_addr} < LIMIT);
      assign rd_ok_a = ({1'b0, rd_addr_a} < LIMIT);
      assign rd_ok_b = ({1'b0, rd_addr_b} < LIMIT);
    end
  endgenerate

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv       (rsv),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .rsv_ok    (rsv_ok),
    .busy_next (busy_next)
  );

  // Write-back into storage; out-of-range writes never reach here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= alu_out;
    end
  end

  // Next value of read port a: storage (or bypassed write data) plus busy.
  always_comb begin
    rd_a_d = '0;
    if (rd_ok_a) begin
      rd_a_d.busy = busy_next[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr_a)) begin
        rd_a_d.data[DATA_W-1:0] = alu_out;
      end else begin
        rd_a_d.data[DATA_W-1:0] = regs[rd_addr_a];
      end
`else
      rd_a_d.data[DATA_W-1:0] = regs[rd_addr_a];
`endif
    end
  end

  // Next value of read port b, same rules as port a.
  always_comb begin
    rd_b_d = '0;
    if (rd_ok_b) begin
      rd_b_d.busy = busy_next[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr_b)) begin
        rd_b_d.data[DATA_W-1:0] = alu_out;
      end else begin
        rd_b_d.data[DATA_W-1:0] = regs[rd_addr_b];
      end
`else
      rd_b_d.data[DATA_W-1:0] = regs[rd_addr_b];
`endif
    end
  end

  // Registered read ports (one-cycle read latency).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign data_out_a = rd_a_q.data[DATA_W-1:0];
  assign data_out_b = rd_b_q.data[DATA_W-1:0];
  assign busy_a     = rd_a_q.busy;
  assign busy_b     = rd_b_q.busy;

  // Record bits above DATA_W are always zero and intentionally left unread.
  logic unused_rd_bits;
  assign unused_rd_bits = ^{rd_a_q.data, rd_b_q.data};

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: an 8-entry instance for the
// main behaviour and a 6-entry instance for out-of-range addresses.
module tb_register_file;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // 8-register instance
  logic       save, rsv, flush;
  logic [2:0] wr_addr, rd_addr_a, rd_addr_b, rsv_addr;
  logic [7:0] alu_out, data_out_a, data_out_b;
  logic       busy_a, busy_b, rsv_ok;

  // 6-register instance
  logic       save6, rsv6, flush6;
  logic [2:0] wr_addr6, rd_addr_a6, rd_addr_b6, rsv_addr6;
  logic [7:0] alu_out6, data_out_a6, data_out_b6;
  logic       busy_a6, busy_b6, rsv_ok6;

  register_file #(.DATA_W(8), .NUM_REGS(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .save(save), .wr_addr(wr_addr),
    .alu_out(alu_out), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .data_out_a(data_out_a), .data_out_b(data_out_b),
    .busy_a(busy_a), .busy_b(busy_b), .rsv(rsv), .rsv_addr(rsv_addr),
    .rsv_ok(rsv_ok), .flush(flush)
  );

  register_file #(.DATA_W(8), .NUM_REGS(6)) u_dut6 (
    .clk(clk), .reset_n(reset_n), .save(save6), .wr_addr(wr_addr6),
    .alu_out(alu_out6), .rd_addr_a(rd_addr_a6), .rd_addr_b(rd_addr_b6),
    .data_out_a(data_out_a6), .data_out_b(data_out_b6),
    .busy_a(busy_a6), .busy_b(busy_b6), .rsv(rsv6), .rsv_addr(rsv_addr6),
    .rsv_ok(rsv_ok6), .flush(flush6)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    save = 1'b0; rsv = 1'b0; flush = 1'b0;
    wr_addr = '0; alu_out = '0; rd_addr_a = '0; rd_addr_b = '0; rsv_addr = '0;
    save6 = 1'b0; rsv6 = 1'b0; flush6 = 1'b0;
    wr_addr6 = '0; alu_out6 = '0; rd_addr_a6 = '0; rd_addr_b6 = '0; rsv_addr6 = '0;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    save = 1'b1; wr_addr = a; alu_out = d;
    tick();
    save = 1'b0;
  endtask

  logic [7:0] exp_bypass_3c;
  logic [7:0] exp_bypass_77;

  initial begin
`ifdef REGFILE_BYPASS_EN
    exp_bypass_3c = 8'h3C;
    exp_bypass_77 = 8'h77;
`else
    exp_bypass_3c = 8'h11;
    exp_bypass_77 = 8'h00;
`endif
    reset_n = 1'b0;
    drive_idle();
    tick();
    tick();
    check("reset_data_a", data_out_a, 8'h00);
    check("reset_data_b", data_out_b, 8'h00);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_rsv_ok", rsv_ok, 1'b0);
    check("reset6_data_a", data_out_a6, 8'h00);
    reset_n = 1'b1;

    // ---- asynchronous reset mid-operation ----
    write_reg(3'd3, 8'h5A);
    rsv = 1'b1; rsv_addr = 3'd3; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    tick();
    rsv = 1'b0;
    check("pre_reset_data_a", data_out_a, 8'h5A);
    check("pre_reset_busy_b", busy_b, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_data_a", data_out_a, 8'h00);
    check("async_reset_busy_b", busy_b, 1'b0);
    #1 reset_n = 1'b1;
    tick();
    check("post_reset_r3", data_out_a, 8'h00);
    check("post_reset_busy3", busy_b, 1'b0);

    // ---- basic write / read on both ports ----
    write_reg(3'd2, 8'hA5);
    rd_addr_a = 3'd2; rd_addr_b = 3'd2;
    tick();
    check("read_a_r2", data_out_a, 8'hA5);
    check("read_b_r2", data_out_b, 8'hA5);

    // ---- same-edge write and read ----
    write_reg(3'd4, 8'h11);
    save = 1'b1; wr_addr = 3'd4; alu_out = 8'h3C; rd_addr_a = 3'd4;
    tick();
    save = 1'b0;
    check("same_edge_r4", data_out_a, exp_bypass_3c);
    tick();
    check("next_edge_r4", data_out_a, 8'h3C);

    // ---- scoreboard reserve / re-reserve / clear ----
    rsv = 1'b1; rsv_addr = 3'd5;
    #1 check("rsv_r5_ok", rsv_ok, 1'b1);
    tick();
    check("rsv_r5_again", rsv_ok, 1'b0);
    rsv = 1'b0; rd_addr_a = 3'd5;
    tick();
    check("busy_a_r5", busy_a, 1'b1);
    save = 1'b1; wr_addr = 3'd5; alu_out = 8'h77;
    tick();
    save = 1'b0;
    check("busy_clear_r5", busy_a, 1'b0);
    check("same_edge_r5", data_out_a, exp_bypass_77);
    tick();
    check("read_r5", data_out_a, 8'h77);
    check("read_r5_busy", busy_a, 1'b0);

    // ---- save and reserve of a busy register on the same cycle ----
    rsv = 1'b1; rsv_addr = 3'd1;
    tick();
    check("busy_r1_blocks", rsv_ok, 1'b0);
    save = 1'b1; wr_addr = 3'd1; alu_out = 8'h42; rd_addr_a = 3'd1;
    #1 check("save_rsv_r1_ok", rsv_ok, 1'b1);
    tick();
    save = 1'b0; rsv = 1'b0;
    check("save_rsv_r1_busy", busy_a, 1'b1);
    tick();
    check("save_rsv_r1_data", data_out_a, 8'h42);
    check("save_rsv_r1_busy2", busy_a, 1'b1);

    // ---- flush beats a same-cycle reserve; data untouched ----
    flush = 1'b1; rsv = 1'b1; rsv_addr = 3'd6; rd_addr_b = 3'd6;
    #1 check("flush_rsv_r6_ok", rsv_ok, 1'b1);
    tick();
    flush = 1'b0; rsv = 1'b0;
    check("flush_busy_r6", busy_b, 1'b0);
    check("flush_busy_r1", busy_a, 1'b0);
    check("flush_keeps_r1", data_out_a, 8'h42);
    rsv = 1'b1; rsv_addr = 3'd1;
    #1 check("rsv_r1_after_flush", rsv_ok, 1'b1);
    tick();
    rsv = 1'b0;

    // ---- NUM_REGS=6: out-of-range addresses ----
    save6 = 1'b1; wr_addr6 = 3'd5; alu_out6 = 8'hC3;
    tick();
    save6 = 1'b1; wr_addr6 = 3'd7; alu_out6 = 8'hFF;
    tick();
    save6 = 1'b0;
    rd_addr_a6 = 3'd7; rd_addr_b6 = 3'd5;
    tick();
    check("oor_read_r7", data_out_a6, 8'h00);
    check("oor_busy_r7", busy_a6, 1'b0);
    check("in_range_r5", data_out_b6, 8'hC3);
    rsv6 = 1'b1; rsv_addr6 = 3'd7;
    #1 check("oor_rsv_r7", rsv_ok6, 1'b0);
    rsv_addr6 = 3'd4;
    #1 check("rsv6_r4_ok", rsv_ok6, 1'b1);
    rd_addr_b6 = 3'd4;
    tick();
    rsv6 = 1'b0;
    check("rsv6_r4_busy", busy_b6, 1'b1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
